// File: rtl/cpu_ctrl_if.sv
// Program-memory bus between cpu_ctrl and its instruction ROM.
// Ports: adr (3-bit instruction address, driven by the controller),
//        instr (3N+3-bit instruction word, returned combinationally by memory).
interface cpu_ctrl_if #(parameter int N = 8) ();
  logic [2:0]     adr;
  logic [3*N+2:0] instr;

  // Controller side: presents the address, samples the word.
  modport master (output adr, input instr);
  // Memory side: decodes the address, returns the word.
  modport slave  (input adr, output instr);
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute controller over an 8-entry, N-bit register file.
// Ports: clk, rst_n (sync active-low), start, mem (instruction bus, master side),
//        dbg_sel/dbg_data (combinational register read), busy, halted, carry.
// Latency: 4 clocks per non-halt instruction; HALT is reached 2 clocks after its FETCH.
// Backpressure: none -- memory is assumed to answer in the cycle adr is presented.
module cpu_ctrl #(
  parameter int N = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  cpu_ctrl_if.master    mem,
  input  logic [2:0]    dbg_sel,
  output logic [N-1:0]  dbg_data,
  output logic          busy,
  output logic          halted,
  output logic          carry
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT
  } state_t;

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_MOVR = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t       state;
  logic [2:0]   pc;

  // Instruction register: only the fields that matter are kept. Register
  // indices use the low 3 bits of their field; the src1 field is kept in
  // full because it doubles as the MOVI immediate and the JMP target.
  logic [2:0]   ir_op;
  logic [2:0]   ir_dst;
  logic [N-1:0] ir_imm;
  logic [2:0]   ir_s2;

  logic [N-1:0] opa;
  logic [N-1:0] opb;
  logic [N-1:0] res;
  logic         carry_q;
  logic [N-1:0] regs [8];

  logic [N:0]   alu_wide;
  logic [N-1:0] alu_res;
  logic         alu_c;

  // Sum/difference are formed one bit wider so bit N is carry (ADD) or
  // borrow (SUB, set exactly when opa < opb unsigned).
  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    case (ir_op)
      OP_MOVI, OP_MOVR: alu_res = opa;
      OP_ADD: begin
        alu_wide = {1'b0, opa} + {1'b0, opb};
        alu_res  = alu_wide[N-1:0];
        alu_c    = alu_wide[N];
      end
      OP_SUB: begin
        alu_wide = {1'b0, opa} - {1'b0, opb};
        alu_res  = alu_wide[N-1:0];
        alu_c    = alu_wide[N];
      end
      OP_AND:  alu_res = opa & opb;
      OP_OR:   alu_res = opa | opb;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      ir_op   <= '0;
      ir_dst  <= '0;
      ir_imm  <= '0;
      ir_s2   <= '0;
      opa     <= '0;
      opb     <= '0;
      res     <= '0;
      carry_q <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          // Restart from address 0; register contents carry over.
          if (start) begin
            pc    <= '0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          ir_op  <= mem.instr[3*N+2:3*N];
          ir_dst <= mem.instr[2*N+2:2*N];
          ir_imm <= mem.instr[2*N-1:N];
          ir_s2  <= mem.instr[2:0];
          state  <= S_DECODE;
        end
        S_DECODE: begin
          // Operands are captured here, so a dest that aliases a source
          // still sees the pre-instruction value.
          opa   <= (ir_op == OP_MOVI) ? ir_imm : regs[ir_imm[2:0]];
          opb   <= regs[ir_s2];
          state <= (ir_op == OP_HALT) ? S_HALT : S_EXECUTE;
        end
        S_EXECUTE: begin
          res <= alu_res;
          if (ir_op == OP_ADD || ir_op == OP_SUB) carry_q <= alu_c;
          state <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          if (ir_op != OP_JMP && ir_op != OP_HALT) regs[ir_dst] <= res;
          pc    <= (ir_op == OP_JMP) ? ir_imm[2:0] : pc + 3'd1;
          state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mem.adr  = pc;
  assign dbg_data = regs[dbg_sel];
  assign busy     = (state != S_IDLE) && (state != S_HALT);
  assign halted   = (state == S_HALT);
  assign carry    = carry_q;

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
- Multi-cycle fetch/decode/execute controller that sits directly downstream of the program memory.
- Drives the 3-bit instruction address into the memory and captures the 3N+3-bit instruction word it returns combinationally.
- Executes each instruction against an internal 8-entry, N-bit register file.
- Exposes a debug read port and status flags to the top level.

Parameters:
- N, 8, data width of registers and of each instruction operand field (N >= 3).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk
- start  in  1  single-cycle pulse; begins execution from address 0 when idle or halted
- instr  in  3N+3  instruction word from program memory: [3N+2:3N] op, [3N-1:2N] dest, [2N-1:N] src1/imm, [N-1:0] src2
- adr  out  3  instruction address (program counter)
- dbg_sel  in  3  register index for debug read
- dbg_data  out  N  combinational read of reg[dbg_sel]
- busy  out  1  high in any state other than IDLE and HALT
- halted  out  1  high in HALT state
- carry  out  1  carry/borrow flag from last ADD/SUB

Behaviour:
- Reset (rst_n=0 at clock edge):
  - state=IDLE, pc=0, IR=0, all registers=0, carry=0.
  - Outputs: adr=0, busy=0, halted=0.
  - Reset dominates start and overrides any state, including mid-instruction; no partial writeback survives.
- Register index = low 3 bits of the dest/src field; upper bits are ignored.
- Opcodes:
  - 000 MOVI: dest <= src1 field (immediate).
  - 001 MOVR: dest <= reg[src1].
  - 010 ADD: dest <= reg[src1]+reg[src2] mod 2^N; carry <= bit N of the sum.
  - 011 SUB: dest <= reg[src1]-reg[src2] mod 2^N; carry <= 1 on borrow (src1 < src2 unsigned).
  - 100 AND, 101 OR: bitwise; carry unchanged.
  - 110 JMP: pc <= src1[2:0]; no register write.
  - 111 HALT.
- An all-zero instruction word is a legal MOVI reg0,0.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- IDLE:
  - Wait; start=1 -> FETCH with pc=0.
- FETCH:
  - adr=pc; IR <= instr.
  - Next state DECODE.
- DECODE:
  - Operand registers A <= reg[src1], B <= reg[src2] (or immediate for MOVI).
  - Op 111 -> HALT; otherwise -> EXECUTE.
- EXECUTE:
  - ALU result and carry registered.
  - Next state WRITEBACK.
- WRITEBACK:
  - Register write for ops 000-101.
  - pc <= pc+1, wrapping 7->0; JMP loads the target instead.
  - Next state FETCH.
- Timing:
  - 4 clocks per non-halt instruction.
  - A written register is visible on dbg_data the cycle after WRITEBACK.
  - HALT takes effect 2 clocks after FETCH.
- HALT:
  - halted=1, busy=0; pc holds the HALT address; registers retained.
  - start=1 -> pc=0, halted=0, FETCH; registers are not cleared.
- Control rules:
  - start while busy is ignored.
  - adr is always driven from pc, never X.
  - No handshake with memory; instr is assumed valid in the same cycle adr is presented.
  - dest equal to a source register is legal: operands are read in DECODE, so the old value is used.

Test Plan:
- Program mem {MOVI r0,5; MOVI r1,7; ADD r2,r0,r1; rest zero}, start pulse -> after 12 clocks dbg_data(sel=2)=12, r0=5, r1=7, carry=0, adr=3.
- Same program run 8 instructions (32 clocks) -> adr wraps to 0; r0=0 (zero words executed as MOVI r0,0); r2=12 retained.
- Stub ROM {MOVI r0,200; MOVI r1,100; ADD r2,r0,r1; SUB r3,r1,r0; HALT} (N=8) -> r2=44, carry=1 after ADD; r3=156, carry=1 after SUB; halted=1, busy=0, adr=4.
- Stub ROM {MOVI r5,3; JMP 6; ...; [6] HALT} -> pc goes 0,1,6; no write from skipped addresses; halted=1 with adr=6.
- rst_n=0 asserted during EXECUTE of ADD -> next cycle state IDLE, all regs 0, adr=0, busy=0; start pulse then re-runs cleanly.
- start pulsed while busy -> no effect on pc/sequence; start pulsed in HALT -> restarts at adr=0 with registers preserved.
